// File: rtl/grf_mp.sv
// grf_mp: multi-port general register file with two write ports,
// per-register pending bits and a registered pending count.
// Optional same-cycle write-to-read forwarding: define GRF_MP_BYPASS_EN.
module grf_mp #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NRD*AW-1:0] RAddr,
    output logic [NRD*DW-1:0] RData,
    output logic [NRD-1:0]    RBusy,
    input  logic              WE0,
    input  logic [AW-1:0]     WA0,
    input  logic [DW-1:0]     WD0,
    input  logic              WE1,
    input  logic [AW-1:0]     WA1,
    input  logic [DW-1:0]     WD1,
    input  logic              IssueEn,
    input  logic [AW-1:0]     IssueAddr,
    output logic [AW:0]       PendCnt
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0]    regs [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic             cnt_inc;
    logic             cnt_dec0;
    logic             cnt_dec1;
    logic             wr0_ok;
    logic             wr1_ok;
    logic             iss_ok;

    logic [AW-1:0]    ra;
    logic [DW-1:0]    rd;
    logic             rb;

    assign wr0_ok = WE0 && (WA0 != '0);
    assign wr1_ok = WE1 && (WA1 != '0);
    assign iss_ok = IssueEn && (IssueAddr != '0);

    // Data array: port 1 is applied after port 0 so it wins on an address clash
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr0_ok) regs[WA0] <= WD0;
            if (wr1_ok) regs[WA1] <= WD1;
        end
    end

    // Next pending vector: writes clear, issue sets, issue dominates a same-register write
    always_comb begin
        pend_nxt = pend;
        pend_nxt[0] = 1'b0;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            if ((wr0_ok && WA0 == AW'(i)) || (wr1_ok && WA1 == AW'(i))) begin
                pend_nxt[i] = 1'b0;
            end
            if (iss_ok && IssueAddr == AW'(i)) begin
                pend_nxt[i] = 1'b1;
            end
        end
    end

    // Count events: only real 0->1 and 1->0 transitions move the counter.
    // A second write to the same register as port 0 must not decrement twice.
    always_comb begin
        cnt_inc  = iss_ok && !pend[IssueAddr];
        cnt_dec0 = wr0_ok && pend[WA0] && !(iss_ok && IssueAddr == WA0);
        cnt_dec1 = wr1_ok && pend[WA1] && !(iss_ok && IssueAddr == WA1)
                   && !(wr0_ok && WA0 == WA1);
    end

    // Pending bits and the pending counter update together
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend    <= '0;
            PendCnt <= '0;
        end else begin
            pend    <= pend_nxt;
            PendCnt <= PendCnt + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec0) - (AW+1)'(cnt_dec1);
        end
    end

    // Combinational read ports, with optional forwarding of this cycle's writes
    always_comb begin
        RData = '0;
        RBusy = '0;
        ra    = '0;
        rd    = '0;
        rb    = 1'b0;
        for (int unsigned k = 0; k < NRD; k++) begin
            ra = RAddr[k*AW +: AW];
            rd = regs[ra];
            rb = pend[ra];
`ifdef GRF_MP_BYPASS_EN
            if (wr1_ok && WA1 == ra) begin
                rd = WD1;
                rb = (iss_ok && IssueAddr == ra) ? pend[ra] : 1'b0;
            end else if (wr0_ok && WA0 == ra) begin
                rd = WD0;
                rb = (iss_ok && IssueAddr == ra) ? pend[ra] : 1'b0;
            end
`endif
            if (ra == '0) begin
                rd = '0;
                rb = 1'b0;
            end
            RData[k*DW +: DW] = rd;
            RBusy[k]          = rb;
        end
    end

endmodule

// File: doc/grf_mp.md
# grf_mp

Parametrised multi-port general register file for the pipelined CPU core. It replaces the single-write, two-read GRF and provides:
- configurable data width, depth and read-port count;
- two write ports (ALU/MEM writeback pairs);
- per-register pending (scoreboard) bits with a live pending count, used by the hazard unit to stall issue;
- optional write-to-read bypass.

## Interface
Parameters:
- DW, 32, data width in bits
- AW, 5, address width; depth = 2**AW registers
- NRD, 2, number of read ports (1..8)

Ports:
- Clk  in  1  clock, all state updates on posedge
- Reset  in  1  synchronous, active-high reset
- RAddr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
- RData  out  NRD*DW  read data; port k uses bits [k*DW +: DW]
- RBusy  out  NRD  1 = register addressed by port k is pending
- WE0  in  1  write enable, port 0
- WA0  in  AW  write address, port 0
- WD0  in  DW  write data, port 0
- WE1  in  1  write enable, port 1
- WA1  in  AW  write address, port 1
- WD1  in  DW  write data, port 1
- IssueEn  in  1  mark IssueAddr pending
- IssueAddr  in  AW  destination register of the issued instruction
- PendCnt  out  AW+1  number of registers currently pending

## Operation
- Register 0 reads as 0 and is never pending.
  - Writes to address 0 are discarded.
  - Issue to address 0 is ignored.
- Write rules:
  - Both write ports are active in the same cycle.
  - If WA0 == WA1 with both enabled, port 1 wins for both the array and the bypass.
- Pending rules:
  - A write with WEx=1 to a nonzero register clears its pending bit.
  - IssueEn=1 sets the pending bit for IssueAddr.
  - If IssueEn and a write hit the same register in the same cycle, issue wins: the bit stays or becomes 1 and the write data is still stored.
- PendCnt equals the population count of the pending bits and is maintained as a registered counter.
  - Per cycle, the counter applies the net of set and clear events.
  - Re-issuing an already-pending register does not increment it.
  - Clearing a non-pending register does not decrement it.
  - Two writes to the same pending register decrement it once.
- Read paths are combinational.
  - RData[k] = stored value of RAddr[k], modified by bypass when it is compiled in.
  - RBusy[k] = pending[RAddr[k]], modified by bypass when it is compiled in.
- Reset: all registers, all pending bits and PendCnt become 0 at the clock edge where Reset=1.
  - Reset has priority over concurrent writes and issues.
  - After that edge: RData = 0, RBusy = 0, PendCnt = 0.

## Timing
- Writes and pending updates take effect at the posedge.
  - Without bypass, the new value or state is readable the cycle after the write.
- Issue at edge N makes RBusy = 1 from the cycle after edge N.
- Read latency is 0 cycles (combinational from RAddr and state).
- PendCnt is a registered output, updated at the same edge as the pending bits.
- Reset asserted in the middle of a sequence of writes discards the in-flight write of that cycle.

## Configuration
- GRF_MP_BYPASS_EN defined: same-cycle forwarding is enabled.
  - If WEx=1, WAx == RAddr[k] and RAddr[k] != 0, then RData[k] = WDx, with port 1 having priority over port 0.
  - In that case RBusy[k] = 0, unless the register is being re-issued this cycle; the new pending state from that issue is visible next cycle.
- Not defined: RData and RBusy reflect stored state only, and a write becomes visible one cycle later.
- Pending and count logic are identical in both builds.

## Test plan
- Reset: write all registers with nonzero data, then pulse Reset -> every RData = 0, RBusy = 0, PendCnt = 0.
- Dual write conflict: WE0 = WE1 = 1, WA0 = WA1 = 5, WD0 = 0x11111111, WD1 = 0x22222222 -> next cycle R5 reads 0x22222222.
  - With bypass, R5 also reads 0x22222222 in the same cycle.
- Register 0: write 0xDEADBEEF to address 0 and issue to 0 -> R0 reads 0, RBusy = 0, PendCnt unchanged.
- Scoreboard:
  - Issue 3, 7 and 3 on consecutive cycles -> PendCnt = 2.
  - Then WE0 to 7 simultaneously with issue to 9 -> PendCnt = 2.
  - Then a same-cycle write to 3 and issue to 3 -> R3 stays pending, PendCnt = 2.
- Bypass (macro on): R4 = 0x0, same-cycle WE1 to 4 with 0xCAFEF00D and RAddr[0] = 4 -> RData[0] = 0xCAFEF00D in that cycle.
  - With the macro off, the same stimulus gives RData[0] = 0x0 in that cycle and 0xCAFEF00D in the next.
- Reset mid-operation: Reset asserted together with a WE0 write and an issue -> after the edge the target register reads 0 and PendCnt = 0.
